// File: rtl/pwm_pkg.sv
// Shared constants and types for the multi-channel PWM generator.
package pwm_pkg;

    localparam int CH_DEFAULT = 4;
    localparam int CW_DEFAULT = 8;

    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTER = 1'b1;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: registered compare of the upcoming count against the upcoming duty.
module pwm_chan #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [CW-1:0] cnt_next,
    input  logic [CW-1:0] duty_next,
    output logic          pwm_out
);

    logic pwm_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_reg <= 1'b0;
        end else begin
            pwm_reg <= en && (cnt_next < duty_next);
        end
    end

    assign pwm_out = pwm_reg;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared edge/center counter, double-buffered period/duty/mode,
// cycle_start and upd_ack strobes.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int CH = CH_DEFAULT,
    parameter int CW = CW_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [CW-1:0]    period,
    input  logic [CH*CW-1:0] duty,
    input  logic             center,
    output logic [CH-1:0]    pwm_out,
    output logic             cycle_start,
    output logic             upd_ack
);

    logic [CW-1:0]    cnt_reg, cnt_next, cnt_inc;
    dir_t             dir_reg, dir_next;
    logic             run_reg;
    logic [CW-1:0]    per_act_reg, per_act_next, per_sh_reg, per_sh_next;
    logic [CH*CW-1:0] duty_act_reg, duty_act_next, duty_sh_reg, duty_sh_next;
    logic             mode_act_reg, mode_act_next, mode_sh_reg, mode_sh_next;
    logic             pending_reg, pending_next;
    logic             cycle_start_reg, cycle_start_next;
    logic             upd_ack_reg, upd_ack_next;
    logic             boundary;

    assign cnt_inc = cnt_reg + CW'(1);

    always_comb begin
        cnt_next         = cnt_reg;
        dir_next         = dir_reg;
        per_act_next     = per_act_reg;
        duty_act_next    = duty_act_reg;
        mode_act_next    = mode_act_reg;
        per_sh_next      = per_sh_reg;
        duty_sh_next     = duty_sh_reg;
        mode_sh_next     = mode_sh_reg;
        pending_next     = pending_reg;
        cycle_start_next = 1'b0;
        upd_ack_next     = 1'b0;
        boundary         = 1'b0;

        if (!en) begin
            // Stopped: loads bypass the shadow stage, and a leftover pending update is flushed.
            cnt_next     = '0;
            dir_next     = DIR_UP;
            pending_next = 1'b0;
            if (load) begin
                per_act_next  = period;
                duty_act_next = duty;
                mode_act_next = center;
                per_sh_next   = period;
                duty_sh_next  = duty;
                mode_sh_next  = center;
                upd_ack_next  = 1'b1;
            end else if (pending_reg) begin
                per_act_next  = per_sh_reg;
                duty_act_next = duty_sh_reg;
                mode_act_next = mode_sh_reg;
                upd_ack_next  = 1'b1;
            end
        end else begin
            if (!run_reg) begin
                cnt_next         = '0;
                dir_next         = DIR_UP;
                cycle_start_next = 1'b1;
            end else begin
                if (per_act_reg == '0) begin
                    boundary = 1'b1;
                end else if (mode_act_reg == MODE_EDGE) begin
                    if (cnt_reg >= per_act_reg) boundary = 1'b1;
                    else                        cnt_next = cnt_inc;
                end else if (dir_reg == DIR_UP) begin
                    cnt_next = cnt_inc;
                    dir_next = (cnt_inc >= per_act_reg) ? DIR_DOWN : DIR_UP;
                end else if (cnt_reg <= CW'(1)) begin
                    boundary = 1'b1;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end

                if (boundary) begin
                    cnt_next         = '0;
                    dir_next         = DIR_UP;
                    cycle_start_next = 1'b1;
                    if (pending_reg) begin
                        per_act_next  = per_sh_reg;
                        duty_act_next = duty_sh_reg;
                        mode_act_next = mode_sh_reg;
                        upd_ack_next  = 1'b1;
                        pending_next  = 1'b0;
                    end
                end
            end
            // A load on the boundary edge itself waits for the following boundary.
            if (load) begin
                per_sh_next  = period;
                duty_sh_next = duty;
                mode_sh_next = center;
                pending_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg         <= '0;
            dir_reg         <= DIR_UP;
            run_reg         <= 1'b0;
            per_act_reg     <= '1;
            duty_act_reg    <= '0;
            mode_act_reg    <= MODE_EDGE;
            per_sh_reg      <= '1;
            duty_sh_reg     <= '0;
            mode_sh_reg     <= MODE_EDGE;
            pending_reg     <= 1'b0;
            cycle_start_reg <= 1'b0;
            upd_ack_reg     <= 1'b0;
        end else begin
            cnt_reg         <= cnt_next;
            dir_reg         <= dir_next;
            run_reg         <= en;
            per_act_reg     <= per_act_next;
            duty_act_reg    <= duty_act_next;
            mode_act_reg    <= mode_act_next;
            per_sh_reg      <= per_sh_next;
            duty_sh_reg     <= duty_sh_next;
            mode_sh_reg     <= mode_sh_next;
            pending_reg     <= pending_next;
            cycle_start_reg <= cycle_start_next;
            upd_ack_reg     <= upd_ack_next;
        end
    end

    // Channels compare against the duty that will be active alongside cnt_next.
    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_chan
            pwm_chan #(.CW(CW)) u_chan (
                .clk      (clk),
                .rst_n    (rst_n),
                .en       (en),
                .cnt_next (cnt_next),
                .duty_next(duty_act_next[gi*CW +: CW]),
                .pwm_out  (pwm_out[gi])
            );
        end
    endgenerate

    assign cycle_start = cycle_start_reg;
    assign upd_ack     = upd_ack_reg;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed plus randomized bench for pwm_multi, checked against a cycle-position model.
module tb_pwm_multi;

    localparam int CH = 4;
    localparam int CW = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             load = 1'b0;
    logic [CW-1:0]    period = '0;
    logic [CH*CW-1:0] duty = '0;
    logic             center = 1'b0;
    logic [CH-1:0]    pwm_out;
    logic             cycle_start;
    logic             upd_ack;

    int errors = 0;
    int checks = 0;

    pwm_multi #(.CH(CH), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .period     (period),
        .duty       (duty),
        .center     (center),
        .pwm_out    (pwm_out),
        .cycle_start(cycle_start),
        .upd_ack    (upd_ack)
    );

    always #5 clk = ~clk;

    // Reference model: position within the current cycle, cnt derived arithmetically.
    int         m_pos, m_per, m_sh_per;
    bit         m_run, m_mode, m_sh_mode, m_pending;
    int         m_duty[CH], m_sh_duty[CH];
    logic [CH-1:0] e_pwm;
    logic       e_cs, e_ack;

    function automatic int m_len();
        if (m_mode) return (m_per == 0) ? 1 : 2 * m_per;
        return m_per + 1;
    endfunction

    function automatic int m_cnt();
        if (m_mode && m_pos > m_per) return 2 * m_per - m_pos;
        return m_pos;
    endfunction

    task automatic model_edge();
        e_cs  = 1'b0;
        e_ack = 1'b0;
        if (!rst_n) begin
            m_pos = 0; m_run = 0; m_per = 255; m_sh_per = 255;
            m_mode = 0; m_sh_mode = 0; m_pending = 0;
            for (int i = 0; i < CH; i++) begin m_duty[i] = 0; m_sh_duty[i] = 0; end
            e_pwm = '0;
            return;
        end
        if (!en) begin
            if (load) begin
                m_per = period; m_sh_per = period; m_mode = center; m_sh_mode = center;
                for (int i = 0; i < CH; i++) begin
                    m_duty[i] = duty[i*CW +: CW]; m_sh_duty[i] = m_duty[i];
                end
                e_ack = 1'b1;
            end else if (m_pending) begin
                m_per = m_sh_per; m_mode = m_sh_mode;
                for (int i = 0; i < CH; i++) m_duty[i] = m_sh_duty[i];
                e_ack = 1'b1;
            end
            m_pending = 0; m_pos = 0; m_run = 0; e_pwm = '0;
            return;
        end
        if (!m_run) begin
            m_run = 1; m_pos = 0; e_cs = 1'b1;
        end else begin
            m_pos++;
            if (m_pos >= m_len()) begin
                m_pos = 0; e_cs = 1'b1;
                if (m_pending) begin
                    m_per = m_sh_per; m_mode = m_sh_mode;
                    for (int i = 0; i < CH; i++) m_duty[i] = m_sh_duty[i];
                    e_ack = 1'b1; m_pending = 0;
                end
            end
        end
        if (load) begin
            m_sh_per = period; m_sh_mode = center; m_pending = 1;
            for (int i = 0; i < CH; i++) m_sh_duty[i] = duty[i*CW +: CW];
        end
        for (int i = 0; i < CH; i++) e_pwm[i] = (m_cnt() < m_duty[i]);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("cycle_outputs", {26'd0, pwm_out, cycle_start, upd_ack}, {26'd0, e_pwm, e_cs, e_ack});
    endtask

    function automatic logic [CH*CW-1:0] mkd(input int d3, input int d2, input int d1, input int d0);
        return {d3[CW-1:0], d2[CW-1:0], d1[CW-1:0], d0[CW-1:0]};
    endfunction

    task automatic do_load(input int p, input logic [CH*CW-1:0] d, input logic c);
        load = 1'b1; period = p[CW-1:0]; duty = d; center = c;
        $display("load period=%0d duty=%h center=%0d en=%0d", p, d, c, en);
        step();
        load = 1'b0;
    endtask

    task automatic wait_ack();
        int n = 0;
        while (!upd_ack && n < 600) begin step(); n++; end
        chk("wait_upd_ack", {31'd0, upd_ack}, 32'd1);
    endtask

    task automatic wait_cnt(input int k);
        int n = 0;
        while ((m_cnt() != k || !m_run) && n < 600) begin step(); n++; end
        chk("wait_cnt", m_cnt(), k);
    endtask

    // Measures the cycle beginning at the next (or current) cycle_start.
    task automatic measure(input string tag, input int exp_len, input int exp_hi);
        int n = 0, len = 0, hi = 0;
        while (!cycle_start && n < 600) begin step(); n++; end
        do begin
            hi += int'(pwm_out[1]);
            len++;
            step();
        end while (!cycle_start && len < 600);
        $display("measure %s len=%0d ch1_high=%0d", tag, len, hi);
        chk({tag, "_len"}, len, exp_len);
        chk({tag, "_high"}, hi, exp_hi);
    endtask

    initial begin
        int acks, highs;
        // 1: reset then edge mode
        rst_n = 1'b0; en = 1'b0;
        step(); step();
        chk("reset_outputs", {29'd0, pwm_out[0], cycle_start, upd_ack}, 32'd0);
        rst_n = 1'b1; en = 1'b1;
        do_load(9, mkd(15, 10, 3, 0), 1'b0);
        wait_ack();
        measure("edge", 10, 3);

        // 2: center mode
        do_load(4, mkd($urandom_range(0, 9), $urandom_range(0, 9), 2, $urandom_range(0, 9)), 1'b1);
        measure("center", 8, 3);
        measure("center_again", 8, 3);

        // 3: mid-cycle load
        do_load(9, mkd($urandom_range(0, 12), $urandom_range(0, 12), 3, $urandom_range(0, 12)), 1'b0);
        wait_ack();
        wait_cnt(5);
        do_load(9, mkd($urandom_range(0, 12), $urandom_range(0, 12), 7, $urandom_range(0, 12)), 1'b0);
        chk("midload_no_early_ack", {31'd0, upd_ack}, 32'd0);
        measure("midload", 10, 7);

        // 4: load on the boundary edge, then two loads in one cycle
        wait_cnt(9);
        do_load(9, mkd(0, 0, 5, 0), 1'b0);
        chk("coincident_cs", {31'd0, cycle_start}, 32'd1);
        chk("coincident_no_ack", {31'd0, upd_ack}, 32'd0);
        measure("coincident_old", 10, 7);
        measure("coincident_new", 10, 5);
        wait_cnt(2);
        do_load(9, mkd(1, 1, 2, 1), 1'b0);
        do_load(9, mkd(4, 4, 6, 4), 1'b0);
        measure("double_load", 10, 6);

        // 5: en drop and restart
        wait_cnt(6);
        en = 1'b0;
        step();
        chk("disabled_pwm", {28'd0, pwm_out}, 32'd0);
        do_load(3, mkd(2, 1, 2, 3), 1'b0);
        chk("disabled_ack", {31'd0, upd_ack}, 32'd1);
        step();
        en = 1'b1;
        step();
        chk("restart_cs", {31'd0, cycle_start}, 32'd1);
        measure("restart", 4, 2);

        // 6: reset mid-operation with an update pending
        do_load(9, mkd(3, 3, 3, 3), 1'b0);
        wait_ack();
        do_load(20, mkd(200, 200, 200, 200), 1'b0);
        wait_cnt(5);
        rst_n = 1'b0;
        step();
        chk("midreset_outputs", {28'd0, pwm_out, cycle_start, upd_ack} >> 2, 32'd0);
        rst_n = 1'b1;
        acks = 0; highs = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            acks += int'(upd_ack);
            highs += int'(|pwm_out);
        end
        chk("midreset_no_ack", acks, 0);
        chk("midreset_pwm_low", highs, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
            else rst_n = 1'b1;
            if ($urandom_range(0, 63) == 0) en = ~en;
            if ($urandom_range(0, 7) == 0) begin
                do_load($urandom_range(0, 12),
                        mkd($urandom_range(0, 14), $urandom_range(0, 14),
                            $urandom_range(0, 14), $urandom_range(0, 14)),
                        1'($urandom_range(0, 1)));
            end else begin
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
